tlc_multiway: RTL and testbench
===============================

# tlc_multiway

Parametrised N-approach traffic light controller, successor to the fixed four-way countdown controller. It sequences green, yellow and all-red clearance phases round-robin across `N_WAYS` approaches, with per-phase durations set by parameters. Approaches without vehicle demand are skipped, and green is held while no other approach is waiting. An emergency preempt input forces a chosen approach to green. The block sits between the sensor/preempt inputs and the lamp drivers. It exposes the active phase index and remaining time for the display logic.

## Interface
Parameters:
- `N_WAYS`, 4: number of approaches. Legal range 2..8.
- `TW`, 4: width of the phase timer. It must hold `max(GREEN_T, YELLOW_T, ALLRED_T) - 1`.
- `GREEN_T`, 8: green duration, in enabled cycles. Must be ≥ 1.
- `YELLOW_T`, 3: yellow duration, in enabled cycles. Must be ≥ 1.
- `ALLRED_T`, 2: all-red clearance duration, in enabled cycles. Must be ≥ 1.
- `IW` (derived) = clog2(`N_WAYS`): width of the phase index.

Ports:
- `clk`, in, 1: the single clock. All state updates occur on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `enable`, in, 1: clock-enable tick. State, timer and index change only on edges where `enable` = 1.
- `demand`, in, `N_WAYS`: per-approach vehicle presence. Level-sensitive.
- `preempt`, in, 1: emergency request. Level-sensitive.
- `preempt_idx`, in, `IW`: approach to force to green. Values ≥ `N_WAYS` are treated as 0.
- `green`, out, `N_WAYS`: one-hot lamp output, or all zero.
- `yellow`, out, `N_WAYS`: one-hot lamp output, or all zero.
- `red`, out, `N_WAYS`: equals ~(`green` | `yellow`).
- `phase`, out, `IW`: active approach index.
- `time_left`, out, `TW`: remaining enabled cycles in the current state, minus 1.
- `in_preempt`, out, 1: high while the preempt hold is active.

## Operation
- FSM states: ALLRED, GREEN, YELLOW.
  - Registers: `state`, `phase`, `timer`.
  - Outputs are a Moore decode of these registers. No output depends combinationally on the inputs.
  - In GREEN: `green[phase]` = 1. In YELLOW: `yellow[phase]` = 1. In ALLRED: all lamps are red.
- Reset values:
  - `state` = ALLRED, `phase` = `N_WAYS-1`, `timer` = `ALLRED_T-1`.
  - Hence `red` is all ones, `green` = `yellow` = 0, `time_left` = `ALLRED_T-1`, `in_preempt` = 0.
- Each enabled edge with `timer` ≠ 0 decrements `timer`, unless a rule below overrides.
- On an enabled edge with `timer` = 0:
  - GREEN → YELLOW. `timer` = `YELLOW_T-1`.
  - YELLOW → ALLRED. `timer` = `ALLRED_T-1`.
  - ALLRED → GREEN. `phase` = next approach, `timer` = `GREEN_T-1`.
- Next-approach selection, applied at ALLRED expiry:
  - If `preempt` = 1: `preempt_idx`.
  - Otherwise, the first j with `demand[j]` = 1, searching (`phase`+1) … (`phase`+`N_WAYS`) mod `N_WAYS`. The current phase is the last candidate.
  - If no approach has demand: (`phase`+1) mod `N_WAYS`, i.e. a fixed cycle.
- Green rest: in GREEN at `timer` = 0, if no j ≠ `phase` has `demand[j]`, and `preempt` = 0, then stay GREEN and reload `timer` = `GREEN_T-1`.
- Preempt, evaluated on enabled edges. It takes priority over the timer rules.
  - In GREEN with `phase` ≠ `preempt_idx`: go to YELLOW immediately, `timer` = `YELLOW_T-1`.
  - In GREEN with `phase` = `preempt_idx`: hold, `timer` = `GREEN_T-1`, `in_preempt` = 1.
  - In YELLOW or ALLRED: normal countdown. Clearance is never shortened.
  - On release (`preempt` = 0 while `in_preempt` = 1): `in_preempt` = 0, `timer` = `GREEN_T-1`, then normal operation.
  - A `preempt_idx` change while holding is treated like a GREEN with a mismatched index: go to YELLOW.
- Yellow and all-red are always served in full. No direct green-to-green change ever occurs, including across preempt.

## Timing
- A state's length is its T value in enabled cycles: `timer` counts T-1 down to 0, and the transition occurs on the following enabled edge.
- From reset release with `enable` held at 1:
  - `green[0]` rises after edge `ALLRED_T`.
  - One full phase lasts `GREEN_T+YELLOW_T+ALLRED_T` cycles.
- Inputs are sampled only on enabled edges. `demand` or `preempt` pulses that fall between enabled edges are ignored.
- Preempt reaction, from the first enabled edge seeing `preempt`=1, up to the target green: at most `YELLOW_T+ALLRED_T+1` enabled edges.
- Reset asserted mid-phase: outputs immediately return to the reset values, regardless of `clk`.
- `enable` = 0: all registers hold and the outputs are static.

## Test plan
- Setup for all cases: `N_WAYS`=4, `GREEN_T`=8, `YELLOW_T`=3, `ALLRED_T`=2.
- Reset release, `enable`=1, `demand`=4'b1111:
  - `green[0]` high after edge 2, for 8 cycles.
  - `yellow[0]` from edge 10, for 3 cycles.
  - All red from edge 13.
  - `green[1]` from edge 15.
  - `phase` sequence 0,1,2,3,0.
- `demand`=4'b0101: phases alternate 0,2,0, with no green on 1 or 3.
- `demand`=4'b0001 only: `green[0]` stays on indefinitely, with `time_left` cycling 7→0→7.
- `preempt`=1, `preempt_idx`=2, asserted at the 3rd green cycle of phase 0:
  - Next enabled edge: `yellow[0]`.
  - Then 3 yellow cycles, 2 all-red cycles, then `green[2]` with `in_preempt`=1, held until release.
  - After release: 8 further green cycles.
- `enable` toggled at 1/3 duty: every duration is stretched exactly 3×, with lamp sequence unchanged.
- Reset asserted asynchronously during yellow: outputs immediately all red, `time_left`=1, `phase`=3. Then the sequence restarts as in the first scenario.

Source files
------------

// File: rtl/tlc_multiway.sv
// N-approach traffic light controller: round-robin green/yellow/all-red sequencing with
// demand skipping, green rest and emergency preempt. Lamp outputs are registered.
module tlc_multiway #(
    parameter int unsigned N_WAYS   = 4,
    parameter int unsigned TW       = 4,
    parameter int unsigned GREEN_T  = 8,
    parameter int unsigned YELLOW_T = 3,
    parameter int unsigned ALLRED_T = 2,
    localparam int unsigned IW      = $clog2(N_WAYS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [N_WAYS-1:0] demand,
    input  logic              preempt,
    input  logic [IW-1:0]     preempt_idx,
    output logic [N_WAYS-1:0] green,
    output logic [N_WAYS-1:0] yellow,
    output logic [N_WAYS-1:0] red,
    output logic [IW-1:0]     phase,
    output logic [TW-1:0]     time_left,
    output logic              in_preempt
);

    typedef enum logic [1:0] {StAllRed, StGreen, StYellow} state_e;

    localparam logic [TW-1:0] GreenLoad  = TW'(GREEN_T - 1);
    localparam logic [TW-1:0] YellowLoad = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] AllRedLoad = TW'(ALLRED_T - 1);

    state_e              state_q, state_d;
    logic [IW-1:0]       phase_q, phase_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                hold_q, hold_d;
    logic [N_WAYS-1:0]   green_q, green_d;
    logic [N_WAYS-1:0]   yellow_q, yellow_d;

    logic [IW-1:0]       pidx;
    logic [IW-1:0]       next_idx;
    logic [IW-1:0]       cand_idx;
    logic                found;
    logic                others_waiting;

    // Out-of-range preempt targets fall back to approach 0.
    always_comb begin
        pidx = preempt_idx;
        if (int'(preempt_idx) >= int'(N_WAYS)) begin
            pidx = '0;
        end
    end

    // First demanding approach after the current one; the current phase is searched last.
    always_comb begin
        next_idx = IW'((int'(phase_q) + 1) % int'(N_WAYS));
        cand_idx = '0;
        found    = 1'b0;
        for (int k = 1; k <= int'(N_WAYS); k++) begin
            cand_idx = IW'((int'(phase_q) + k) % int'(N_WAYS));
            if (!found && demand[cand_idx]) begin
                found    = 1'b1;
                next_idx = cand_idx;
            end
        end
        if (preempt) begin
            next_idx = pidx;
        end
    end

    assign others_waiting = |(demand & ~(N_WAYS'(1) << phase_q));

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        timer_d = timer_q;
        hold_d  = hold_q;
        if (enable) begin
            unique case (state_q)
                StGreen: begin
                    if (preempt) begin
                        if (phase_q != pidx) begin
                            state_d = StYellow;
                            timer_d = YellowLoad;
                            hold_d  = 1'b0;
                        end else begin
                            timer_d = GreenLoad;
                            hold_d  = 1'b1;
                        end
                    end else if (hold_q) begin
                        hold_d  = 1'b0;
                        timer_d = GreenLoad;
                    end else if (timer_q != '0) begin
                        timer_d = timer_q - 1'b1;
                    end else if (others_waiting) begin
                        state_d = StYellow;
                        timer_d = YellowLoad;
                    end else begin
                        timer_d = GreenLoad;
                    end
                end
                StYellow: begin
                    if (timer_q != '0) begin
                        timer_d = timer_q - 1'b1;
                    end else begin
                        state_d = StAllRed;
                        timer_d = AllRedLoad;
                    end
                end
                default: begin
                    if (timer_q != '0) begin
                        timer_d = timer_q - 1'b1;
                    end else begin
                        state_d = StGreen;
                        phase_d = next_idx;
                        timer_d = GreenLoad;
                        hold_d  = preempt;
                    end
                end
            endcase
        end
    end

    always_comb begin
        green_d  = '0;
        yellow_d = '0;
        if (state_d == StGreen) begin
            green_d = N_WAYS'(1) << phase_d;
        end
        if (state_d == StYellow) begin
            yellow_d = N_WAYS'(1) << phase_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StAllRed;
            phase_q  <= IW'(N_WAYS - 1);
            timer_q  <= AllRedLoad;
            hold_q   <= 1'b0;
            green_q  <= '0;
            yellow_q <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            timer_q  <= timer_d;
            hold_q   <= hold_d;
            green_q  <= green_d;
            yellow_q <= yellow_d;
        end
    end

    assign green      = green_q;
    assign yellow     = yellow_q;
    assign red        = ~(green_q | yellow_q);
    assign phase      = phase_q;
    assign time_left  = timer_q;
    assign in_preempt = hold_q;

endmodule

// File: tb/tb_tlc_multiway.sv
// Bench for tlc_multiway (4 ways, 8/3/2): reference model feeding a scoreboard queue,
// a table of checkpoint vectors, and hand sequences for preempt, slow enable and async reset.
module tb_tlc_multiway;

    localparam int G_T = 8;
    localparam int Y_T = 3;
    localparam int A_T = 2;
    localparam int ST_AR = 0;
    localparam int ST_G  = 1;
    localparam int ST_Y  = 2;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] demand;
    logic       preempt;
    logic [1:0] preempt_idx;
    logic [3:0] green;
    logic [3:0] yellow;
    logic [3:0] red;
    logic [1:0] phase;
    logic [3:0] time_left;
    logic       in_preempt;

    tlc_multiway #(
        .N_WAYS   (4),
        .TW       (4),
        .GREEN_T  (G_T),
        .YELLOW_T (Y_T),
        .ALLRED_T (A_T)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .demand      (demand),
        .preempt     (preempt),
        .preempt_idx (preempt_idx),
        .green       (green),
        .yellow      (yellow),
        .red         (red),
        .phase       (phase),
        .time_left   (time_left),
        .in_preempt  (in_preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] g;
        logic [3:0] y;
        logic [1:0] ph;
        logic [3:0] tl;
        logic       hold;
    } obs_t;

    typedef struct {
        logic [3:0] dem;
        int         n;
        obs_t       exp;
    } vec_t;

    obs_t exp_q[$];
    vec_t vecs[16];
    int   checks = 0;
    int   errors = 0;

    int m_st, m_ph, m_t;
    bit m_hold;

    function automatic obs_t model_obs();
        obs_t o;
        o.g    = (m_st == ST_G) ? (4'b0001 << m_ph) : 4'b0000;
        o.y    = (m_st == ST_Y) ? (4'b0001 << m_ph) : 4'b0000;
        o.ph   = 2'(m_ph);
        o.tl   = 4'(m_t);
        o.hold = m_hold;
        return o;
    endfunction

    function automatic obs_t mk(logic [3:0] g, logic [3:0] y, int ph, int tl, bit h);
        obs_t o;
        o.g = g; o.y = y; o.ph = 2'(ph); o.tl = 4'(tl); o.hold = h;
        return o;
    endfunction

    task automatic model_reset();
        m_st = ST_AR; m_ph = 3; m_t = A_T - 1; m_hold = 0;
    endtask

    function automatic int pick(logic [3:0] dem, bit pre, int pidx);
        if (pre) return pidx;
        for (int k = 1; k <= 4; k++) begin
            if (dem[(m_ph + k) % 4]) return (m_ph + k) % 4;
        end
        return (m_ph + 1) % 4;
    endfunction

    task automatic model_step(bit en, logic [3:0] dem, bit pre, int pidx);
        if (!en) return;
        if (m_st == ST_G) begin
            if (pre && m_ph != pidx) begin
                m_st = ST_Y; m_t = Y_T - 1; m_hold = 0;
            end else if (pre) begin
                m_t = G_T - 1; m_hold = 1;
            end else if (m_hold) begin
                m_hold = 0; m_t = G_T - 1;
            end else if (m_t > 0) begin
                m_t--;
            end else if ((dem & ~(4'b0001 << m_ph)) != 4'b0000) begin
                m_st = ST_Y; m_t = Y_T - 1;
            end else begin
                m_t = G_T - 1;
            end
        end else if (m_t > 0) begin
            m_t--;
        end else if (m_st == ST_Y) begin
            m_st = ST_AR; m_t = A_T - 1;
        end else begin
            m_ph = pick(dem, pre, pidx);
            m_st = ST_G; m_t = G_T - 1; m_hold = pre;
        end
    endtask

    task automatic check(input string name, input obs_t exp);
        obs_t act;
        act = {green, yellow, phase, time_left, in_preempt};
        checks++;
        if (act !== exp || red !== ~(exp.g | exp.y)) begin
            errors++;
            $display("FAIL %s: got g=%b y=%b r=%b ph=%0d tl=%0d hold=%b, want g=%b y=%b ph=%0d tl=%0d hold=%b",
                     name, green, yellow, red, phase, time_left, in_preempt,
                     exp.g, exp.y, exp.ph, exp.tl, exp.hold);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Drive one clock worth of inputs; the model's prediction is queued, then compared after the edge.
    task automatic cycle(input bit en, input logic [3:0] dem, input bit pre, input logic [1:0] pidx);
        enable = en; demand = dem; preempt = pre; preempt_idx = pidx;
        model_step(en, dem, pre, int'(pidx));
        exp_q.push_back(model_obs());
        @(posedge clk);
        #1;
        check("cycle", exp_q.pop_front());
    endtask

    task automatic run(input int n, input logic [3:0] dem, input bit pre, input logic [1:0] pidx);
        for (int i = 0; i < n; i++) cycle(1'b1, dem, pre, pidx);
    endtask

    initial begin
        int n_g0, n_y0, n_ar, first_g0, first_g1;

        vecs[0]  = '{4'b1111,  2, mk(4'b0001, 4'b0000, 0, 7, 0)};
        vecs[1]  = '{4'b1111,  8, mk(4'b0000, 4'b0001, 0, 2, 0)};
        vecs[2]  = '{4'b1111,  3, mk(4'b0000, 4'b0000, 0, 1, 0)};
        vecs[3]  = '{4'b1111,  2, mk(4'b0010, 4'b0000, 1, 7, 0)};
        vecs[4]  = '{4'b1111, 13, mk(4'b0100, 4'b0000, 2, 7, 0)};
        vecs[5]  = '{4'b1111, 13, mk(4'b1000, 4'b0000, 3, 7, 0)};
        vecs[6]  = '{4'b1111, 13, mk(4'b0001, 4'b0000, 0, 7, 0)};
        vecs[7]  = '{4'b0101,  8, mk(4'b0000, 4'b0001, 0, 2, 0)};
        vecs[8]  = '{4'b0101,  3, mk(4'b0000, 4'b0000, 0, 1, 0)};
        vecs[9]  = '{4'b0101,  2, mk(4'b0100, 4'b0000, 2, 7, 0)};
        vecs[10] = '{4'b0101, 13, mk(4'b0001, 4'b0000, 0, 7, 0)};
        vecs[11] = '{4'b0101, 13, mk(4'b0100, 4'b0000, 2, 7, 0)};
        vecs[12] = '{4'b0001, 13, mk(4'b0001, 4'b0000, 0, 7, 0)};
        vecs[13] = '{4'b0001,  8, mk(4'b0001, 4'b0000, 0, 7, 0)};
        vecs[14] = '{4'b0001,  4, mk(4'b0001, 4'b0000, 0, 3, 0)};
        vecs[15] = '{4'b0001,  4, mk(4'b0001, 4'b0000, 0, 7, 0)};

        reset = 1'b1; enable = 1'b0; demand = 4'b0; preempt = 1'b0; preempt_idx = 2'd0;
        model_reset();
        #3;
        check("reset_state", mk(4'b0000, 4'b0000, 3, 1, 0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int v = 0; v < 16; v++) begin
            run(vecs[v].n, vecs[v].dem, 1'b0, 2'd0);
            check($sformatf("vec%0d", v), vecs[v].exp);
        end

        // Preempt to approach 2 from the third green cycle of approach 0.
        run(2, 4'b1111, 1'b0, 2'd0);
        check("pre_third_green", mk(4'b0001, 4'b0000, 0, 5, 0));
        run(1, 4'b1111, 1'b1, 2'd2);
        check("pre_yellow_now", mk(4'b0000, 4'b0001, 0, 2, 0));
        run(5, 4'b1111, 1'b1, 2'd2);
        check("pre_target_green", mk(4'b0100, 4'b0000, 2, 7, 1));
        run(10, 4'b1111, 1'b1, 2'd2);
        check("pre_hold", mk(4'b0100, 4'b0000, 2, 7, 1));
        run(1, 4'b1111, 1'b0, 2'd2);
        check("pre_release", mk(4'b0100, 4'b0000, 2, 7, 0));
        run(7, 4'b1111, 1'b0, 2'd2);
        check("post_release_green", mk(4'b0100, 4'b0000, 2, 0, 0));
        run(1, 4'b1111, 1'b0, 2'd2);
        check("post_release_yellow", mk(4'b0000, 4'b0100, 2, 2, 0));
        run(5, 4'b1111, 1'b1, 2'd1);
        check("pre_hold_idx1", mk(4'b0010, 4'b0000, 1, 7, 1));
        run(1, 4'b1111, 1'b1, 2'd2);
        check("pre_idx_change", mk(4'b0000, 4'b0010, 1, 2, 0));
        run(6, 4'b1111, 1'b0, 2'd0);

        // Slow enable: one enabled edge in three.
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_g0 = 0; n_y0 = 0; n_ar = 0; first_g0 = -1; first_g1 = -1;
        for (int i = 0; i < 300 && first_g1 < 0; i++) begin
            cycle(i % 3 == 0, 4'b1111, 1'b0, 2'd0);
            if (green == 4'b0001) begin
                n_g0++;
                if (first_g0 < 0) first_g0 = i;
            end
            if (yellow == 4'b0001) n_y0++;
            if (first_g0 >= 0 && red == 4'b1111) n_ar++;
            if (green == 4'b0010) first_g1 = i;
        end
        check_int("slow_first_green0", first_g0, 3);
        check_int("slow_green0_len", n_g0, 3 * G_T);
        check_int("slow_yellow0_len", n_y0, 3 * Y_T);
        check_int("slow_allred_len", n_ar, 3 * A_T);
        check_int("slow_first_green1", first_g1, 42);

        // Asynchronous reset during yellow, then restart.
        for (int i = 0; i < 40 && yellow == 4'b0000; i++) cycle(1'b1, 4'b1111, 1'b0, 2'd0);
        check_int("reached_yellow", int'(yellow != 4'b0000), 1);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("async_reset", mk(4'b0000, 4'b0000, 3, 1, 0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        run(2, 4'b1111, 1'b0, 2'd0);
        check("restart_green0", mk(4'b0001, 4'b0000, 0, 7, 0));
        run(13, 4'b1111, 1'b0, 2'd0);
        check("restart_green1", mk(4'b0010, 4'b0000, 1, 7, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
